seq_divider: RTL

- Multi-cycle radix-2 restoring divider that responds to the EX-stage ALU's divide request handshake (start/ready).
- Serves DIV and DIVU; the ALU holds start high and stalls the pipeline until ready is asserted, then writes result into HI/LO.
- result[63:32] is the remainder (HI); result[31:0] is the quotient (LO).

---
 rtl/seq_divider.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle radix-2 restoring divider with start/ready handshake
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Holds the (absolute) dividend while shifting out and collects quotient bits
    // in from the LSB; in the divide-by-zero path it holds the raw dividend.
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               signed_q, signed_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   sub;
    logic [WIDTH-1:0]   quot_next;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;

    // One restoring step plus sign fixup of the final values.
    always_comb begin
        shifted   = {rem_q, dividend_q[WIDTH-1]};
        ge        = (shifted >= {1'b0, divisor_q});
        // When ge holds the true difference is below 2^WIDTH, so WIDTH bits suffice.
        sub       = shifted[WIDTH-1:0] - divisor_q;
        rem_next  = ge ? sub : shifted[WIDTH-1:0];
        quot_next = {dividend_q[WIDTH-2:0], ge};
        quot_fix  = (signed_q && (sign1_q ^ sign2_q)) ? (~quot_next + 1'b1) : quot_next;
        rem_fix   = (signed_q && sign1_q) ? (~rem_next + 1'b1) : rem_next;
        abs1      = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
        abs2      = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
    end

    // Next-state and output logic; annul beats iteration and completion.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    signed_d = signed_div;
                    sign1_d  = opdata1[WIDTH-1];
                    sign2_d  = opdata2[WIDTH-1];
                    if (opdata2 == '0) begin
                        state_d    = BYZERO;
                        dividend_d = opdata1;
                        divisor_d  = '0;
                    end else begin
                        state_d    = BUSY;
                        cnt_d      = '0;
                        rem_d      = '0;
                        dividend_d = abs1;
                        divisor_d  = abs2;
                    end
                end
            end
            BYZERO: begin
                if (annul) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = DONE;
                    ready_d  = 1'b1;
                    result_d = {dividend_q, {WIDTH{1'b1}}};
                end
            end
            BUSY: begin
                if (annul) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    rem_d      = rem_next;
                    dividend_d = quot_next;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            DONE: begin
                if (annul || !start) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // State register with synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule
